ddr3_app_burst_ctrl: RTL and testbench



---
 rtl/ddr3_pkg.sv | 17 +
 rtl/ddr3_app_burst_ctrl_if.sv | 31 +++
 rtl/ddr3_rd_watchdog.sv | 34 +++
 rtl/ddr3_app_burst_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ddr3_app_burst_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 application-interface burst engine:
// command codes, address width and the engine state encoding.
package ddr3_pkg;

    localparam int unsigned DDR3_ADDR_W = 29;

    localparam logic [2:0] DDR3_CMD_WR = 3'b000;
    localparam logic [2:0] DDR3_CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StDone
    } ddr3_state_e;

endpackage

// File: rtl/ddr3_app_burst_ctrl_if.sv
// DDR3 controller user application interface (command, write-data, read-data).
// master = burst engine side, slave = controller side.
interface ddr3_app_burst_ctrl_if;
    import ddr3_pkg::*;

    logic [DDR3_ADDR_W-1:0] app_addr;
    logic [2:0]             app_cmd;
    logic                   app_en;
    logic                   app_rdy;
    logic [255:0]           app_wdf_data;
    logic [31:0]            app_wdf_mask;
    logic                   app_wdf_wren;
    logic                   app_wdf_end;
    logic                   app_wdf_rdy;
    logic [255:0]           app_rd_data;
    logic                   app_rd_data_valid;
    logic                   app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
               app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
               app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/ddr3_rd_watchdog.sv
// Read-return watchdog: counts idle cycles while running, reloads on each kick,
// and pulses expire_o once 2^Width cycles pass without a kick.
module ddr3_rd_watchdog #(
    parameter int unsigned Width = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic kick_i,
    output logic expire_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || kick_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && !kick_i && (cnt_q == '1);

endmodule

// File: rtl/ddr3_app_burst_ctrl.sv
// Burst engine driving the DDR3 controller user interface in the ui_clk domain.
// Optional read watchdog and rd_timeout port under `DDR3_RD_TIMEOUT_EN.
module ddr3_app_burst_ctrl
    import ddr3_pkg::*;
#(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic                   ui_clk,
    input  logic                   sys_rst,
    input  logic                   init_calib_complete,
    input  logic                   wr_start,
    input  logic                   rd_start,
    input  logic [DDR3_ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]       burst_len,
    input  logic [255:0]           wr_din,
    input  logic                   wr_din_valid,
    output logic                   wr_din_ready,
    output logic [255:0]           rd_dout,
    output logic                   rd_dout_valid,
    output logic                   busy,
    output logic                   done,
`ifdef DDR3_RD_TIMEOUT_EN
    output logic                   rd_timeout,
`endif
    ddr3_app_burst_ctrl_if.master  app
);

    localparam logic [LEN_W-1:0] One = LEN_W'(1);

    ddr3_state_e            state_q, state_d;
    logic [DDR3_ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       dcnt_q, dcnt_d;
    logic [LEN_W-1:0]       ccnt_q, ccnt_d;
    logic [LEN_W-1:0]       rcnt_q, rcnt_d;

    logic                   cmd_en;
    logic [2:0]             cmd_code;
    logic                   wdf_wren;
    logic [DDR3_ADDR_W-1:0] addr_off;
    logic                   wd_expire;
    logic                   unused_rd_end;

    assign unused_rd_end = app.app_rd_data_end;

`ifdef DDR3_RD_TIMEOUT_EN
    ddr3_rd_watchdog #(
        .Width (20)
    ) u_rd_watchdog (
        .clk_i    (ui_clk),
        .rst_ni   (sys_rst),
        .run_i    ((state_q == StRd) && (rcnt_q < len_q)),
        .kick_i   (app.app_rd_data_valid),
        .expire_o (wd_expire)
    );
    assign rd_timeout = wd_expire;
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        dcnt_d        = dcnt_q;
        ccnt_d        = ccnt_q;
        rcnt_d        = rcnt_q;
        wr_din_ready  = 1'b0;
        wdf_wren      = 1'b0;
        cmd_en        = 1'b0;
        cmd_code      = DDR3_CMD_WR;
        rd_dout_valid = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                // wr_start has priority; a simultaneous rd_start is dropped
                if (init_calib_complete && (wr_start || rd_start)) begin
                    base_d = base_addr;
                    len_d  = burst_len;
                    dcnt_d = '0;
                    ccnt_d = '0;
                    rcnt_d = '0;
                    if (burst_len == '0) begin
                        state_d = StDone;
                    end else if (wr_start) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                wr_din_ready = app.app_wdf_rdy && (dcnt_q < len_q);
                wdf_wren     = wr_din_valid && wr_din_ready;
                if (wdf_wren) begin
                    dcnt_d = dcnt_q + One;
                end
                // A command is only offered for data already in the write FIFO
                cmd_en = (ccnt_q < dcnt_q);
                if (cmd_en && app.app_rdy) begin
                    ccnt_d = ccnt_q + One;
                end
                if (ccnt_d == len_q) begin
                    state_d = StDone;
                end
            end
            StRd: begin
                cmd_code      = DDR3_CMD_RD;
                cmd_en        = (ccnt_q < len_q);
                rd_dout_valid = app.app_rd_data_valid;
                if (cmd_en && app.app_rdy) begin
                    ccnt_d = ccnt_q + One;
                end
                if (app.app_rd_data_valid) begin
                    rcnt_d = rcnt_q + One;
                end
                if ((rcnt_d == len_q) || wd_expire) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            dcnt_q  <= '0;
            ccnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            ccnt_q  <= ccnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Address is derived from ccnt, so it cannot move while a command waits for app_rdy
    assign addr_off = DDR3_ADDR_W'(ccnt_q) * DDR3_ADDR_W'(ADDR_STEP);

    assign app.app_addr     = base_q + addr_off;
    assign app.app_cmd      = cmd_code;
    assign app.app_en       = cmd_en;
    assign app.app_wdf_data = wr_din;
    assign app.app_wdf_mask = '0;
    assign app.app_wdf_wren = wdf_wren;
    assign app.app_wdf_end  = wdf_wren;

    assign rd_dout = (state_q == StRd) ? app.app_rd_data : '0;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ddr3_app_burst_ctrl.sv
// Directed self-checking bench for ddr3_app_burst_ctrl: writes, wrapping reads,
// backpressure, start arbitration, zero-length bursts and reset mid-read.
module tb_ddr3_app_burst_ctrl;
    import ddr3_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_calib_complete;
    logic         wr_start;
    logic         rd_start;
    logic [28:0]  base_addr;
    logic [15:0]  burst_len;
    logic [255:0] wr_din;
    logic         wr_din_valid;
    logic         wr_din_ready;
    logic [255:0] rd_dout;
    logic         rd_dout_valid;
    logic         busy;
    logic         done;
`ifdef DDR3_RD_TIMEOUT_EN
    logic         rd_timeout;
`endif

    ddr3_app_burst_ctrl_if app_bus ();

    ddr3_app_burst_ctrl #(
        .LEN_W     (16),
        .ADDR_STEP (8)
    ) dut (
        .ui_clk              (clk),
        .sys_rst             (rst_n),
        .init_calib_complete (init_calib_complete),
        .wr_start            (wr_start),
        .rd_start            (rd_start),
        .base_addr           (base_addr),
        .burst_len           (burst_len),
        .wr_din              (wr_din),
        .wr_din_valid        (wr_din_valid),
        .wr_din_ready        (wr_din_ready),
        .rd_dout             (rd_dout),
        .rd_dout_valid       (rd_dout_valid),
        .busy                (busy),
        .done                (done),
`ifdef DDR3_RD_TIMEOUT_EN
        .rd_timeout          (rd_timeout),
`endif
        .app                 (app_bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Write-data source: beat i carries wpat(i)
    int widx = 0;

    function automatic logic [255:0] wpat(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [255:0] rpat(input int i);
        logic [31:0] w;
        w = 32'h5A00_0000 + 32'(i);
        return {8{w}};
    endfunction

    assign wr_din = wpat(widx);

    always @(posedge clk) begin
        if (wr_din_valid && wr_din_ready) widx <= widx + 1;
    end

    // Bus monitor, sampled on the falling edge
    int wren_cnt = 0, cmd_cnt = 0, wr_cmd_cnt = 0, en_cnt = 0, done_cnt = 0, rd_cnt = 0;
    int hold_err = 0, order_err = 0, end_err = 0;
    logic        pend = 1'b0;
    logic [28:0] pend_addr = '0;
    logic [2:0]  pend_cmd = '0;
    logic [28:0]  cmd_addr_q[$];
    logic [2:0]   cmd_code_q[$];
    logic [255:0] wdf_q[$];
    logic [255:0] rd_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (app_bus.app_wdf_wren) begin
                wren_cnt <= wren_cnt + 1;
                wdf_q.push_back(app_bus.app_wdf_data);
            end
            if ((app_bus.app_wdf_wren !== app_bus.app_wdf_end) || (app_bus.app_wdf_mask !== '0))
                end_err <= end_err + 1;
            if (app_bus.app_en) en_cnt <= en_cnt + 1;
            if (app_bus.app_en && app_bus.app_rdy) begin
                cmd_cnt <= cmd_cnt + 1;
                cmd_addr_q.push_back(app_bus.app_addr);
                cmd_code_q.push_back(app_bus.app_cmd);
                if (app_bus.app_cmd == DDR3_CMD_WR) wr_cmd_cnt <= wr_cmd_cnt + 1;
            end
            if (wr_cmd_cnt + ((app_bus.app_en && app_bus.app_rdy &&
                               app_bus.app_cmd == DDR3_CMD_WR) ? 1 : 0) >
                wren_cnt + (app_bus.app_wdf_wren ? 1 : 0))
                order_err <= order_err + 1;
            if (pend && (!app_bus.app_en || app_bus.app_addr !== pend_addr ||
                         app_bus.app_cmd !== pend_cmd))
                hold_err <= hold_err + 1;
            pend      <= app_bus.app_en && !app_bus.app_rdy;
            pend_addr <= app_bus.app_addr;
            pend_cmd  <= app_bus.app_cmd;
            if (done) done_cnt <= done_cnt + 1;
            if (rd_dout_valid) begin
                rd_cnt <= rd_cnt + 1;
                rd_q.push_back(rd_dout);
            end
        end else begin
            pend <= 1'b0;
        end
    end

    task automatic start_burst(input logic wr, input logic rd, input logic [28:0] a,
                               input logic [15:0] l);
        @(posedge clk); #1;
        wr_start = wr; rd_start = rd; base_addr = a; burst_len = l;
        @(posedge clk); #1;
        wr_start = 1'b0; rd_start = 1'b0;
    endtask

    // cyc = number of falling edges until done is seen, -1 on timeout
    task automatic wait_done(input int limit, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        wr_start = 1'b0; rd_start = 1'b0; base_addr = '0; burst_len = '0;
        wr_din_valid = 1'b0;
        app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
        app_bus.app_rd_data = '0; app_bus.app_rd_data_valid = 1'b0;
        app_bus.app_rd_data_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++;
        if (app_bus.app_en !== 1'b0 || app_bus.app_wdf_wren !== 1'b0 || app_bus.app_wdf_end !== 1'b0)
            $display("FAIL reset_app_strobes: en=%b wren=%b end=%b want 000", app_bus.app_en,
                     app_bus.app_wdf_wren, app_bus.app_wdf_end);
        else passed++;
        total++;
        if (app_bus.app_addr !== 29'h0 || app_bus.app_cmd !== 3'b000)
            $display("FAIL reset_addr_cmd: addr=%h cmd=%b want 0/000", app_bus.app_addr,
                     app_bus.app_cmd);
        else passed++;
        total++;
        if (wr_din_ready !== 1'b0 || rd_dout_valid !== 1'b0)
            $display("FAIL reset_user_strobes: ready=%b rvalid=%b want 00", wr_din_ready,
                     rd_dout_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        init_calib_complete = 1'b1;
        app_bus.app_rdy = 1'b1; app_bus.app_wdf_rdy = 1'b1;
    endtask

    task automatic test_write4();
        int q0, w0, wi0, d0, oe0, wr0, ee0, cyc;
        q0 = cmd_addr_q.size(); w0 = wdf_q.size(); wi0 = widx; d0 = done_cnt;
        oe0 = order_err; wr0 = wren_cnt; ee0 = end_err;
        wr_din_valid = 1'b1;
        start_burst(1'b1, 1'b0, 29'h100, 16'd4);
        total++; if (busy !== 1'b1) $display("FAIL wr4_busy: got %b want 1", busy); else passed++;
        wait_done(30, cyc);
        total++;
        if (cyc != 6) $display("FAIL wr4_done_latency: got %0d want 6", cyc); else passed++;
        wr_din_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL wr4_busy_after: got %b want 0", busy); else passed++;
        total++;
        if (wren_cnt - wr0 != 4) $display("FAIL wr4_wren_count: got %0d want 4", wren_cnt - wr0);
        else passed++;
        total++;
        if (cmd_addr_q.size() - q0 != 4)
            $display("FAIL wr4_cmd_count: got %0d want 4", cmd_addr_q.size() - q0);
        else passed++;
        for (int i = 0; i < 4 && q0 + i < cmd_addr_q.size(); i++) begin
            total++;
            if (cmd_addr_q[q0+i] !== 29'(32'h100 + 8 * i) || cmd_code_q[q0+i] !== DDR3_CMD_WR)
                $display("FAIL wr4_cmd%0d: addr=%h cmd=%b want %h/000", i, cmd_addr_q[q0+i],
                         cmd_code_q[q0+i], 29'(32'h100 + 8 * i));
            else passed++;
        end
        for (int i = 0; i < 4 && w0 + i < wdf_q.size(); i++) begin
            total++;
            if (wdf_q[w0+i] !== wpat(wi0 + i))
                $display("FAIL wr4_data%0d: got %h want %h", i, wdf_q[w0+i][31:0],
                         wpat(wi0 + i) % (2 ** 32));
            else passed++;
        end
        total++;
        if (done_cnt - d0 != 1) $display("FAIL wr4_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
        total++;
        if (order_err != oe0 || end_err != ee0)
            $display("FAIL wr4_order_end: order=%0d end=%0d want 0/0", order_err - oe0,
                     end_err - ee0);
        else passed++;
    endtask

    task automatic test_read_wrap();
        int q0, r0, d0;
        logic [28:0] exp_addr [3];
        exp_addr[0] = 29'h1FFF_FFF8; exp_addr[1] = 29'h0; exp_addr[2] = 29'h8;
        q0 = cmd_addr_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        start_burst(1'b0, 1'b1, 29'h1FFF_FFF8, 16'd3);
        repeat (6) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL rd_busy_waiting: got %b want 1", busy); else passed++;
        total++;
        if (cmd_addr_q.size() - q0 != 3)
            $display("FAIL rd_cmd_count: got %0d want 3", cmd_addr_q.size() - q0);
        else passed++;
        for (int i = 0; i < 3 && q0 + i < cmd_addr_q.size(); i++) begin
            total++;
            if (cmd_addr_q[q0+i] !== exp_addr[i] || cmd_code_q[q0+i] !== DDR3_CMD_RD)
                $display("FAIL rd_cmd%0d: addr=%h cmd=%b want %h/001", i, cmd_addr_q[q0+i],
                         cmd_code_q[q0+i], exp_addr[i]);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            app_bus.app_rd_data = rpat(i);
            app_bus.app_rd_data_valid = 1'b1;
        end
        @(posedge clk); #1;
        app_bus.app_rd_data_valid = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1) $display("FAIL rd_done_timing: got %b want 1", done); else passed++;
        @(posedge clk); #1;
        total++;
        if (rd_q.size() - r0 != 3) $display("FAIL rd_beat_count: got %0d want 3", rd_q.size() - r0);
        else passed++;
        for (int i = 0; i < 3 && r0 + i < rd_q.size(); i++) begin
            total++;
            if (rd_q[r0+i] !== rpat(i))
                $display("FAIL rd_data%0d: got %h want %h", i, rd_q[r0+i][31:0],
                         rpat(i) % (2 ** 32));
            else passed++;
        end
        total++;
        if (done_cnt - d0 != 1) $display("FAIL rd_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_backpressure();
        int q0, wr0, he0, oe0, d0, cyc;
        q0 = cmd_addr_q.size(); wr0 = wren_cnt; he0 = hold_err; oe0 = order_err; d0 = done_cnt;
        wr_din_valid = 1'b1;
        start_burst(1'b1, 1'b0, 29'h2000, 16'd6);
        @(posedge clk); @(posedge clk); #1;
        app_bus.app_rdy = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total++;
        if (app_bus.app_en !== 1'b1) $display("FAIL bp_en_during_stall: got %b want 1", app_bus.app_en);
        else passed++;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        app_bus.app_rdy = 1'b1;
        wait_done(60, cyc);
        total++; if (cyc < 0) $display("FAIL bp_done_timeout: got none want done"); else passed++;
        wr_din_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cmd_addr_q.size() - q0 != 6)
            $display("FAIL bp_cmd_count: got %0d want 6", cmd_addr_q.size() - q0);
        else passed++;
        for (int i = 0; i < 6 && q0 + i < cmd_addr_q.size(); i++) begin
            total++;
            if (cmd_addr_q[q0+i] !== 29'(32'h2000 + 8 * i))
                $display("FAIL bp_cmd%0d: got %h want %h", i, cmd_addr_q[q0+i],
                         29'(32'h2000 + 8 * i));
            else passed++;
        end
        total++;
        if (wren_cnt - wr0 != 6) $display("FAIL bp_wren_count: got %0d want 6", wren_cnt - wr0);
        else passed++;
        total++;
        if (hold_err != he0) $display("FAIL bp_hold: got %0d want 0", hold_err - he0); else passed++;
        total++;
        if (order_err != oe0) $display("FAIL bp_order: got %0d want 0", order_err - oe0);
        else passed++;
        total++;
        if (done_cnt - d0 != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_arbitration();
        int q0, d0, cyc;
        q0 = cmd_addr_q.size(); d0 = done_cnt;
        wr_din_valid = 1'b1;
        start_burst(1'b1, 1'b1, 29'h300, 16'd2);
        // rd_start while busy must be ignored
        start_burst(1'b0, 1'b1, 29'h9000, 16'd1);
        wait_done(30, cyc);
        total++; if (cyc < 0) $display("FAIL arb_done_timeout: got none want done"); else passed++;
        wr_din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL arb_busy_after: got %b want 0", busy); else passed++;
        total++;
        if (cmd_addr_q.size() - q0 != 2)
            $display("FAIL arb_cmd_count: got %0d want 2", cmd_addr_q.size() - q0);
        else passed++;
        for (int i = 0; i < 2 && q0 + i < cmd_addr_q.size(); i++) begin
            total++;
            if (cmd_addr_q[q0+i] !== 29'(32'h300 + 8 * i) || cmd_code_q[q0+i] !== DDR3_CMD_WR)
                $display("FAIL arb_cmd%0d: addr=%h cmd=%b want %h/000", i, cmd_addr_q[q0+i],
                         cmd_code_q[q0+i], 29'(32'h300 + 8 * i));
            else passed++;
        end
        total++;
        if (done_cnt - d0 != 1) $display("FAIL arb_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_calib_block();
        int e0, wr0, d0;
        e0 = en_cnt; wr0 = wren_cnt; d0 = done_cnt;
        init_calib_complete = 1'b0;
        wr_din_valid = 1'b1;
        start_burst(1'b1, 1'b0, 29'h500, 16'd2);
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL calib_busy: got %b want 0", busy); else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (en_cnt != e0 || wren_cnt != wr0 || done_cnt != d0)
            $display("FAIL calib_traffic: en=%0d wren=%0d done=%0d want 0/0/0", en_cnt - e0,
                     wren_cnt - wr0, done_cnt - d0);
        else passed++;
        wr_din_valid = 1'b0;
        init_calib_complete = 1'b1;
    endtask

    task automatic test_len_zero();
        int e0, d0;
        e0 = en_cnt; d0 = done_cnt;
        start_burst(1'b1, 1'b0, 29'h600, 16'd0);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b1)
            $display("FAIL len0_done: done=%b busy=%b want 1/1", done, busy);
        else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL len0_idle: got %b want 0", busy); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (en_cnt != e0 || done_cnt - d0 != 1)
            $display("FAIL len0_traffic: en=%0d done=%0d want 0/1", en_cnt - e0, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        int q0, r0, n;
        bit hit;
        q0 = cmd_cnt; r0 = rd_cnt;
        start_burst(1'b0, 1'b1, 29'h4000, 16'd8);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20) begin
            @(posedge clk);
            n++;
            if (cmd_cnt - q0 >= 2) hit = 1'b1;
        end
        total++; if (!hit) $display("FAIL rst_cmds_timeout: got %0d want 2", cmd_cnt - q0); else passed++;
        #2;
        total++;
        if (app_bus.app_cmd !== DDR3_CMD_RD || busy !== 1'b1)
            $display("FAIL rst_pre_state: cmd=%b busy=%b want 001/1", app_bus.app_cmd, busy);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || app_bus.app_en !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_async_strobes: busy=%b en=%b done=%b want 000", busy,
                     app_bus.app_en, done);
        else passed++;
        total++;
        if (app_bus.app_addr !== 29'h0 || app_bus.app_cmd !== 3'b000)
            $display("FAIL rst_async_addr_cmd: addr=%h cmd=%b want 0/000", app_bus.app_addr,
                     app_bus.app_cmd);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        app_bus.app_rd_data = rpat(7);
        app_bus.app_rd_data_valid = 1'b1;
        @(negedge clk);
        total++;
        if (rd_dout_valid !== 1'b0) $display("FAIL rst_stray_rvalid: got %b want 0", rd_dout_valid);
        else passed++;
        @(posedge clk); #1;
        app_bus.app_rd_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cmd_cnt - q0 != 2 || rd_cnt != r0)
            $display("FAIL rst_after: busy=%b cmds=%0d beats=%0d want 0/2/0", busy, cmd_cnt - q0,
                     rd_cnt - r0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write4();
        test_read_wrap();
        test_backpressure();
        test_arbitration();
        test_calib_block();
        test_len_zero();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
